vec_mem_sequencer: RTL and testbench

VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_mem_sequencer_if.sv | 22 ++
 rtl/vec_mem_sequencer.sv | 127 ++++++++++++
 tb/tb_vec_mem_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vec_pkg;

    localparam int LANES  = 16;
    localparam int WORD_W = 32;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef logic [LANES-1:0][WORD_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Word-wide memory port between the vector sequencer (master) and memory (slave).
interface vec_mem_sequencer_if;
    import vec_pkg::*;

    logic [WORD_W-1:0] MemAddr;
    logic [WORD_W-1:0] MemWData;
    logic              MemWE;
    logic              MemRE;
    logic [WORD_W-1:0] MemRData;
    logic              MemReady;

    modport master (
        output MemAddr, MemWData, MemWE, MemRE,
        input  MemRData, MemReady
    );

    modport slave (
        input  MemAddr, MemWData, MemWE, MemRE,
        output MemRData, MemReady
    );

endinterface

// File: rtl/vec_mem_sequencer.sv
// Breaks one 16-lane vector load/store into sequential word accesses on a
// single memory port, stalling the execute stage until the vector is done.
module vec_mem_sequencer
    import vec_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ReqValidE,
    input  logic                 MemWriteE,
    input  logic                 MemtoRegE,
    input  logic [31:0]          BaseAddrE,
    input  vec_t                 StoreDataE,
    input  logic [3:0]           WA3E,
    input  logic                 FlushE,
    vec_mem_sequencer_if.master  mem,
    output logic                 StallE,
    output vec_t                 LoadDataM,
    output logic                 LoadValidM,
    output logic [3:0]           WA3M
);

    state_e             state_q,     state_d;
    logic [LANE_W-1:0]  lane_q,      lane_d;
    logic [31:0]        base_q,      base_d;
    vec_t               store_q,     store_d;
    logic [3:0]         wa3_q,       wa3_d;
    vec_t               load_data_q, load_data_d;
    logic               load_done_q, load_done_d;
    logic [31:0]        mem_addr_q,  mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               mem_we_q,    mem_we_d;
    logic               mem_re_q,    mem_re_d;
    logic               accept;

    // A request is taken only from IDLE, only if it is a real access, and never under flush.
    assign accept = (state_q == IDLE) && ReqValidE && !FlushE && (MemWriteE || MemtoRegE);

    // Next-state, lane/capture registers and the registered memory-port values.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        lane_d      = lane_q;
        base_d      = base_q;
        store_d     = store_q;
        wa3_d       = wa3_q;
        load_data_d = load_data_q;
        load_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MemWriteE ? STORE : LOAD;
                    base_d  = BaseAddrE;
                    store_d = StoreDataE;
                    wa3_d   = WA3E;
                    lane_d  = '0;
                end
            end
            STORE, LOAD: begin
                // Flush beats a same-cycle acknowledge: the loaded word is dropped.
                if (FlushE) begin
                    state_d = IDLE;
                end else if (mem.MemReady) begin
                    if (state_q == LOAD) load_data_d[lane_q] = mem.MemRData;
                    if (lane_q == LANE_LAST) begin
                        state_d     = DONE;
                        load_done_d = (state_q == LOAD);
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Port values are derived from the next-cycle state so they leave a flop directly.
        mem_addr_d  = base_d + {{(32 - LANE_W - 2){1'b0}}, lane_d, 2'b00};
        mem_wdata_d = store_d[lane_d];
        mem_we_d    = (state_d == STORE);
        mem_re_d    = (state_d == LOAD);
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            base_q      <= '0;
            store_q     <= '0;
            wa3_q       <= '0;
            // NOTE: the load vector is architecturally visible, so it is reset like any other flop.
            load_data_q <= '0;
            load_done_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= state_d;
            lane_q      <= lane_d;
            base_q      <= base_d;
            store_q     <= store_d;
            wa3_q       <= wa3_d;
            load_data_q <= load_data_d;
            load_done_q <= load_done_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign mem.MemAddr  = mem_addr_q;
    assign mem.MemWData = mem_wdata_q;
    assign mem.MemWE    = mem_we_q;
    assign mem.MemRE    = mem_re_q;

    // Stall while busy or while accepting; the pipeline may advance during DONE.
    assign StallE     = (state_q == STORE) || (state_q == LOAD) || accept;
    assign LoadDataM  = load_data_q;
    // A flush in the DONE cycle cancels the writeback.
    assign LoadValidM = load_done_q && !FlushE;
    assign WA3M       = wa3_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a write scoreboard and a load-vector queue.
module tb_vec_mem_sequencer;
    import vec_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ReqValidE, MemWriteE, MemtoRegE, FlushE;
    logic [31:0] BaseAddrE;
    vec_t        StoreDataE;
    logic [3:0]  WA3E;
    logic        StallE, LoadValidM;
    vec_t        LoadDataM;
    logic [3:0]  WA3M;

    vec_mem_sequencer_if mem_if ();

    vec_mem_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .ReqValidE  (ReqValidE),
        .MemWriteE  (MemWriteE),
        .MemtoRegE  (MemtoRegE),
        .BaseAddrE  (BaseAddrE),
        .StoreDataE (StoreDataE),
        .WA3E       (WA3E),
        .FlushE     (FlushE),
        .mem        (mem_if),
        .StallE     (StallE),
        .LoadDataM  (LoadDataM),
        .LoadValidM (LoadValidM),
        .WA3M       (WA3M)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    wr_t  wr_q[$];
    vec_t ld_q[$];
    vec_t ld_model;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to a point 2 time units after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Runs one vector access. Lane i data is dbase+i for stores and for load read data.
    // hold_lane/hold_cycles withhold MemReady; flush_lane/rst_lane abort the access (-1 = off).
    task automatic do_access(input bit is_store, input logic [31:0] base, input logic [3:0] wa3,
                             input logic [31:0] dbase, input int hold_lane, input int hold_cycles,
                             input int flush_lane, input int rst_lane);
        vec_t        sd;
        vec_t        exp_vec;
        wr_t         e;
        logic [31:0] exp_addr;
        int          lane      = 0;
        int          held      = 0;
        int          stall_cnt = 0;
        bit          done_seen = 1'b0;

        for (int i = 0; i < LANES; i++) sd[i] = dbase + 32'(i);
        ReqValidE  = 1'b1;
        MemWriteE  = is_store;
        MemtoRegE  = !is_store;
        BaseAddrE  = base;
        StoreDataE = sd;
        WA3E       = wa3;
        #1 check("accept_stall", StallE, 1'b1);

        if (is_store) begin
            for (int i = 0; i < LANES; i++) wr_q.push_back('{base + 32'(4 * i), dbase + 32'(i)});
        end else if (flush_lane < 0) begin
            ld_q.push_back(sd);
        end

        tick();
        ReqValidE = 1'b0;
        MemWriteE = 1'b0;
        MemtoRegE = 1'b0;

        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!(mem_if.MemWE || mem_if.MemRE)) begin
                done_seen = 1'b1;
                break;
            end
            if (StallE) stall_cnt++;

            if (lane == rst_lane) begin
                RST = 1'b1;
                #1;
                check("rst_we",    mem_if.MemWE,   1'b0);
                check("rst_addr",  mem_if.MemAddr, 32'h0);
                check("rst_stall", StallE,         1'b0);
                check("rst_ldata", LoadDataM,      '0);
                wr_q.delete();
                ld_model = '0;
                tick();
                RST = 1'b0;
                tick();
                check("post_rst_we", mem_if.MemWE, 1'b0);
                check("post_rst_re", mem_if.MemRE, 1'b0);
                return;
            end

            if (lane == flush_lane && mem_if.MemRE) begin
                FlushE          = 1'b1;
                mem_if.MemReady = 1'b1;
                mem_if.MemRData = dbase + 32'(lane);
                tick();
                FlushE          = 1'b0;
                mem_if.MemReady = 1'b0;
                check("flush_re",    mem_if.MemRE, 1'b0);
                check("flush_valid", LoadValidM,   1'b0);
                check("flush_stall", StallE,       1'b0);
                for (int i = 0; i < flush_lane; i++) ld_model[i] = dbase + 32'(i);
                check("flush_data", LoadDataM, ld_model);
                tick();
                check("flush_valid2", LoadValidM, 1'b0);
                return;
            end

            exp_addr = base + 32'(4 * lane);
            check("addr", mem_if.MemAddr, exp_addr);
            if (lane == hold_lane && held < hold_cycles) begin
                mem_if.MemReady = 1'b0;
                held++;
            end else begin
                mem_if.MemReady = 1'b1;
                if (mem_if.MemWE) begin
                    check("sb_nonempty", wr_q.size() > 0, 1'b1);
                    if (wr_q.size() > 0) begin
                        e = wr_q.pop_front();
                        check("wr_addr", mem_if.MemAddr,  e.addr);
                        check("wr_data", mem_if.MemWData, e.data);
                    end
                end else begin
                    mem_if.MemRData = dbase + 32'(lane);
                end
                lane++;
            end
            tick();
            mem_if.MemReady = 1'b0;
        end

        check("no_timeout",  done_seen, 1'b1);
        check("done_stall",  StallE, 1'b0);
        check("busy_cycles", stall_cnt, 16 + hold_cycles);
        check("done_valid",  LoadValidM, !is_store);
        if (!is_store) begin
            check("done_wa3m", WA3M, wa3);
            check("ld_nonempty", ld_q.size() > 0, 1'b1);
            if (ld_q.size() > 0) begin
                exp_vec = ld_q.pop_front();
                check("load_data", LoadDataM, exp_vec);
                ld_model = exp_vec;
            end
        end

        // A request presented during DONE must be ignored.
        ReqValidE = 1'b1;
        MemWriteE = 1'b1;
        tick();
        check("done_ignore_we", mem_if.MemWE, 1'b0);
        check("valid_once",     LoadValidM,   1'b0);
        ReqValidE = 1'b0;
        MemWriteE = 1'b0;
        #1 check("idle_stall", StallE, 1'b0);
        check("sb_drained", wr_q.size(), 0);
    endtask

    initial begin
        RST             = 1'b1;
        ReqValidE       = 1'b0;
        MemWriteE       = 1'b0;
        MemtoRegE       = 1'b0;
        FlushE          = 1'b0;
        BaseAddrE       = '0;
        StoreDataE      = '0;
        WA3E            = '0;
        mem_if.MemReady = 1'b0;
        mem_if.MemRData = '0;
        ld_model        = '0;

        tick();
        tick();
        RST = 1'b0;
        tick();
        check("rst_addr0",  mem_if.MemAddr,  32'h0);
        check("rst_wdata0", mem_if.MemWData, 32'h0);
        check("rst_we0",    mem_if.MemWE,    1'b0);
        check("rst_re0",    mem_if.MemRE,    1'b0);
        check("rst_ldata0", LoadDataM,       '0);
        check("rst_valid0", LoadValidM,      1'b0);
        check("rst_wa3m0",  WA3M,            4'h0);
        check("rst_stall0", StallE,          1'b0);

        // Valid with neither load nor store: not accepted.
        ReqValidE = 1'b1;
        #1 check("nop_stall", StallE, 1'b0);
        tick();
        check("nop_we", mem_if.MemWE, 1'b0);
        check("nop_re", mem_if.MemRE, 1'b0);

        // Flush in IDLE blocks a store.
        MemWriteE = 1'b1;
        FlushE    = 1'b1;
        #1 check("idle_flush_stall", StallE, 1'b0);
        tick();
        check("idle_flush_we", mem_if.MemWE, 1'b0);
        ReqValidE = 1'b0;
        MemWriteE = 1'b0;
        FlushE    = 1'b0;
        tick();

        do_access(1'b1, 32'h0000_0100, 4'd0, 32'h0000_00A0, -1, 0, -1, -1);
        do_access(1'b0, 32'h0000_0200, 4'd5, 32'h0000_1000, -1, 0, -1, -1);
        do_access(1'b0, 32'h0000_0200, 4'd3, 32'h0000_3000,  7, 3, -1, -1);
        do_access(1'b0, 32'h0000_0400, 4'd2, 32'h0000_2000, -1, 0,  4, -1);
        do_access(1'b1, 32'hFFFF_FFF8, 4'd0, 32'h0000_0050, -1, 0, -1, -1);
        do_access(1'b1, 32'h0000_0500, 4'd0, 32'h0000_0070, -1, 0, -1,  9);
        do_access(1'b1, 32'h0000_0600, 4'd0, 32'h0000_0090, -1, 0, -1, -1);
        do_access(1'b0, 32'h0000_0700, 4'd9, 32'h0000_4000, -1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
